pft_gather_unit: RTL and testbench
==================================

// Module: pft_gather_unit
// PURPOSE
//  Downstream of the NIT address generator. Turns its per-bank valid/PFT_addr stream into reads of the 32 PFT banks.
//  Holds the centroid feature returned for each group.
//  For every neighbour, emits the relative feature (neighbour - centroid) per lane to the PE array, tagged with repetition.
//  Free-running pipeline with no backpressure; the upstream block has no stall.
// PARAMETERS
//  bank            32  PFT banks and output lanes
//  microaddr_width 5   per-bank read address width
//  DATA_W          16  signed feature word per bank
// PORTS
//  clk            in   1                      single clock, rising edge
//  rstn           in   1                      asynchronous, active-low reset
//  start          in   1                      run start pulse; clears group_count and err
//  is_centroid    in   1                      current valid/PFT_addr is a centroid fetch
//  is_neighbor    in   1                      current valid/PFT_addr is a neighbour fetch
//  valid          in   bank                   lane i set: read bank i
//  PFT_addr       in   bank*microaddr_width   slice i = read address for bank i
//  repetition     in   2                      neighbour repetition tag
//  NIT_done       in   1                      one-cycle end-of-run pulse
//  bank_en        out  bank                   registered read enable per bank
//  bank_addr      out  bank*microaddr_width   registered read address per bank
//  bank_rdata     in   bank*DATA_W            PFT read data, 1 cycle after bank_en
//  out_valid      out  1                      out_data valid this cycle
//  out_mask       out  bank                   lanes carrying real data
//  out_data       out  bank*(DATA_W+1)        signed neighbour-minus-centroid per lane
//  out_rep        out  2                      repetition tag of out_data
//  out_done       out  1                      one-cycle pulse, cycle after last out_valid of run
//  group_count    out  13                     centroids accepted since start
//  err            out  1                      sticky protocol error flag
// BEHAVIOUR
//  Reset: all outputs, centroid register, pipeline tags and counters = 0; cent_ok = 0.
//  Timing: inputs in cycle T.
//   S1 regs: bank_en=valid & {bank{is_centroid|is_neighbor}} and bank_addr, visible T+1.
//   Memory returns bank_rdata in T+2.
//   S2 regs: out_* visible T+3. Latency is 3 cycles, throughput 1 per cycle.
//  Tags: kind (C/N), mask and rep travel alongside S1 and S2.
//  Centroid return (T+2):
//   cent_reg <= rdata of the lowest-index set mask bit; cent_ok <= 1; group_count += 1 (wraps at 13 bits).
//   No out_valid is produced for a centroid.
//  Neighbour return (T+2): at T+3, out_valid=1, out_mask=mask, out_rep=rep.
//   Per lane: out_data[i] = sext(rdata[i]) - sext(cent_reg), DATA_W+1 bits; cannot overflow.
//   Lanes with mask 0 are driven to 0.
//   The centroid latched at T+2 for group g is used by the first neighbour of g (neighbour return is >=T+3).
//  Neighbour with valid=0: still emits out_valid=1, out_mask=0, out_data=0.
//  out_done = NIT_done delayed 3 cycles, a single-cycle pulse. cent_ok clears with out_done.
//  err (sticky; cleared only by reset or start), set on any of:
//   - is_centroid & is_neighbor together: treated as centroid.
//   - centroid valid not one-hot: lowest index used; zero mask keeps the old cent_reg.
//   - neighbour returned while cent_ok=0: cent_reg (0 after reset) still used.
//  start while data is in flight: in-flight beats still complete; only group_count and err clear.
//  Async reset mid-run: pipeline flushed immediately; no out_valid until new inputs arrive.
// TESTING
//  Reset then idle: all outputs 0 for 10 cycles; bank_en stays 0.
//  Centroid
//   - Input: valid=1<<5, addr5=7, rdata5=100.
//   - Then neighbour: valid=all-ones, rdata[i]=i*10, rep=2.
//   - Expect: out_valid at T+3 with out_data[i] = i*10-100; out_rep=2; group_count=1.
//  Back-to-back: C, N, N, N, N, C, N... with N_SAMPLE=3 and NIT_done.
//   - Expect: 12 out_valid, group_count=3, out_done 1 cycle after last out_valid.
//  Signed extremes: centroid=-32768, neighbour=32767 -> out_data=65535 (17-bit), no wrap.
//  Errors, each setting err and holding it until start:
//   - is_centroid & is_neighbor together.
//   - Centroid valid=0x3: lane 0 data used.
//   - Neighbour first after reset: cent_reg=0.
//  Reset asserted at T+2 of a neighbour: no out_valid at T+3; bank_en=0 on release.

Source files
------------

// File: rtl/pft_gather_unit.sv
// -----------------------------------------------------------------------------
// pft_gather_unit
//
// Sits behind the NIT address generator. Each cycle it turns the per-bank
// valid/PFT_addr request into registered reads of the 32 PFT banks. It holds
// the centroid feature of the current group. For every neighbour it emits the
// per-lane relative feature (neighbour - centroid) to the PE array, tagged
// with the repetition code. The pipeline is free-running with no backpressure.
//
// Pipeline (inputs sampled in cycle T):
//   T+1  S1 : bank_en / bank_addr registered; request tags registered
//   T+2  mem: bank_rdata returns; tags registered again to stay aligned
//   T+3  S2 : out_* registered
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   start            run start pulse; clears group_count and err
//   is_centroid      current request is a centroid fetch
//   is_neighbor      current request is a neighbour fetch
//   valid            per-bank read request
//   PFT_addr         per-bank read address (bank slices of microaddr_width)
//   repetition       neighbour repetition tag
//   NIT_done         one-cycle end-of-run pulse from the address generator
//   bank_en          registered per-bank read enable
//   bank_addr        registered per-bank read address
//   bank_rdata       PFT read data, one cycle after bank_en
//   out_valid        out_data valid this cycle (neighbours only)
//   out_mask         lanes carrying real data
//   out_data         signed neighbour-minus-centroid per lane, DATA_W+1 bits
//   out_rep          repetition tag of out_data
//   out_done         NIT_done delayed three cycles
//   group_count      centroids accepted since start (wraps at 13 bits)
//   err              sticky protocol error flag
// -----------------------------------------------------------------------------
module pft_gather_unit #(
    parameter int bank            = 32,
    parameter int microaddr_width = 5,
    parameter int DATA_W          = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            is_centroid,
    input  logic                            is_neighbor,
    input  logic [bank-1:0]                 valid,
    input  logic [bank*microaddr_width-1:0] PFT_addr,
    input  logic [1:0]                      repetition,
    input  logic                            NIT_done,
    output logic [bank-1:0]                 bank_en,
    output logic [bank*microaddr_width-1:0] bank_addr,
    input  logic [bank*DATA_W-1:0]          bank_rdata,
    output logic                            out_valid,
    output logic [bank-1:0]                 out_mask,
    output logic [bank*(DATA_W+1)-1:0]      out_data,
    output logic [1:0]                      out_rep,
    output logic                            out_done,
    output logic [12:0]                     group_count,
    output logic                            err
);

    localparam int OUT_W = DATA_W + 1;

    // Kind of request travelling with each beat.
    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_CENT  = 2'd1,
        KIND_NEIGH = 2'd2
    } kind_e;

    // ---------------- request decode ----------------
    kind_e w_kind;
    logic  w_err_in;

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_kind   = KIND_NONE;
        w_err_in = 1'b0;
        // A request flagged as both kinds is served as a centroid.
        if (is_centroid) begin
            w_kind = KIND_CENT;
        end else if (is_neighbor) begin
            w_kind = KIND_NEIGH;
        end
        w_err_in = (is_centroid & is_neighbor) | (is_centroid & ~$onehot(valid));
    end

    // ---------------- S1: bank requests + tags ----------------
    logic [bank-1:0]                 r_bank_en;
    logic [bank*microaddr_width-1:0] r_bank_addr;
    kind_e                           r_s1_kind;
    logic [1:0]                      r_s1_rep;
    logic                            r_s1_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bank_en   <= '0;
            r_bank_addr <= '0;
            r_s1_kind   <= KIND_NONE;
            r_s1_rep    <= '0;
            r_s1_done   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of its sources.
            r_bank_en   <= valid & {bank{is_centroid | is_neighbor}};
            r_bank_addr <= PFT_addr;
            r_s1_kind   <= w_kind;
            r_s1_rep    <= repetition;
            r_s1_done   <= NIT_done;
        end
    end

    assign bank_en   = r_bank_en;
    assign bank_addr = r_bank_addr;

    // ---------------- tag stage aligned with bank_rdata ----------------
    kind_e           r_s2_kind;
    logic [bank-1:0] r_s2_mask;
    logic [1:0]      r_s2_rep;
    logic            r_s2_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_kind <= KIND_NONE;
            r_s2_mask <= '0;
            r_s2_rep  <= '0;
            r_s2_done <= 1'b0;
        end else begin
            r_s2_kind <= r_s1_kind;
            r_s2_mask <= r_bank_en;
            r_s2_rep  <= r_s1_rep;
            r_s2_done <= r_s1_done;
        end
    end

    // ---------------- return-side datapath ----------------
    logic                  w_cent_ret;
    logic                  w_neigh_ret;
    logic                  w_cent_hit;
    logic [DATA_W-1:0]     w_cent_word;
    logic [bank*OUT_W-1:0] w_diff;
    logic [DATA_W-1:0]     r_cent;
    logic                  r_cent_ok;

    assign w_cent_ret  = (r_s2_kind == KIND_CENT);
    assign w_neigh_ret = (r_s2_kind == KIND_NEIGH);

    // Lowest-index set lane supplies the centroid word: scanning downwards
    // lets the last hit (the lowest index) win.
    always_comb begin
        w_cent_hit  = 1'b0;
        w_cent_word = '0;
        for (int i = bank - 1; i >= 0; i--) begin
            if (r_s2_mask[i]) begin
                w_cent_hit  = 1'b1;
                w_cent_word = bank_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Both operands are sign-extended by one bit, so the difference of two
    // DATA_W-bit signed values always fits in DATA_W+1 bits.
    always_comb begin
        w_diff = '0;
        for (int i = 0; i < bank; i++) begin
            if (r_s2_mask[i]) begin
                w_diff[i*OUT_W +: OUT_W] =
                    {bank_rdata[i*DATA_W + DATA_W - 1], bank_rdata[i*DATA_W +: DATA_W]}
                    - {r_cent[DATA_W-1], r_cent};
            end
        end
    end

    // ---------------- centroid state, counters, error ----------------
    logic [12:0] r_group_count;
    logic        r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cent        <= '0;
            r_cent_ok     <= 1'b0;
            r_group_count <= '0;
            r_err         <= 1'b0;
        end else begin
            // An all-zero centroid mask keeps the previous centroid word.
            if (w_cent_ret && w_cent_hit) begin
                r_cent <= w_cent_word;
            end

            // cent_ok drops together with out_done; a centroid returning in
            // that same cycle belongs to the next run and wins.
            if (w_cent_ret) begin
                r_cent_ok <= 1'b1;
            end else if (r_s2_done) begin
                r_cent_ok <= 1'b0;
            end

            if (start) begin
                r_group_count <= '0;
            end else if (w_cent_ret) begin
                r_group_count <= r_group_count + 13'd1;
            end

            if (start) begin
                r_err <= 1'b0;
            end else if (w_err_in || (w_neigh_ret && !r_cent_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign group_count = r_group_count;
    assign err         = r_err;

    // ---------------- S2: output registers ----------------
    logic                  r_out_valid;
    logic [bank-1:0]       r_out_mask;
    logic [bank*OUT_W-1:0] r_out_data;
    logic [1:0]            r_out_rep;
    logic                  r_out_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_out_data  <= '0;
            r_out_rep   <= '0;
            r_out_done  <= 1'b0;
        end else begin
            r_out_valid <= w_neigh_ret;
            r_out_mask  <= w_neigh_ret ? r_s2_mask : '0;
            r_out_data  <= w_neigh_ret ? w_diff : '0;
            r_out_rep   <= w_neigh_ret ? r_s2_rep : 2'd0;
            r_out_done  <= r_s2_done;
        end
    end

    assign out_valid = r_out_valid;
    assign out_mask  = r_out_mask;
    assign out_data  = r_out_data;
    assign out_rep   = r_out_rep;
    assign out_done  = r_out_done;

endmodule

// File: tb/tb_pft_gather_unit.sv
// -----------------------------------------------------------------------------
// tb_pft_gather_unit
//
// Drives pft_gather_unit with centroid/neighbour requests, models the PFT
// banks as synchronous-read memories, and checks every out_valid beat against
// a scoreboard of expected beats queued when the neighbour request is driven.
// -----------------------------------------------------------------------------
module tb_pft_gather_unit;

    localparam int BANK = 32;
    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int OW   = 17;

    typedef struct {
        logic [BANK-1:0]    mask;
        logic [BANK*OW-1:0] data;
        logic [1:0]         rep;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic                 is_centroid = 1'b0;
    logic                 is_neighbor = 1'b0;
    logic [BANK-1:0]      valid = '0;
    logic [BANK*AW-1:0]   PFT_addr = '0;
    logic [1:0]           repetition = '0;
    logic                 NIT_done = 1'b0;
    logic [BANK-1:0]      bank_en;
    logic [BANK*AW-1:0]   bank_addr;
    logic [BANK*DW-1:0]   bank_rdata;
    logic                 out_valid;
    logic [BANK-1:0]      out_mask;
    logic [BANK*OW-1:0]   out_data;
    logic [1:0]           out_rep;
    logic                 out_done;
    logic [12:0]          group_count;
    logic                 err;

    pft_gather_unit #(.bank(BANK), .microaddr_width(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .is_centroid (is_centroid),
        .is_neighbor (is_neighbor),
        .valid       (valid),
        .PFT_addr    (PFT_addr),
        .repetition  (repetition),
        .NIT_done    (NIT_done),
        .bank_en     (bank_en),
        .bank_addr   (bank_addr),
        .bank_rdata  (bank_rdata),
        .out_valid   (out_valid),
        .out_mask    (out_mask),
        .out_data    (out_data),
        .out_rep     (out_rep),
        .out_done    (out_done),
        .group_count (group_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    // PFT bank model: synchronous read, data one cycle after bank_en.
    logic [DW-1:0] mem [BANK][32];
    always @(posedge clk) begin
        for (int i = 0; i < BANK; i++) begin
            if (bank_en[i]) bank_rdata[i*DW +: DW] <= mem[i][bank_addr[i*AW +: AW]];
        end
    end

    int               n_checks = 0;
    int               n_pass = 0;
    int               cyc = 0;
    int               n_out = 0;
    int               n_done = 0;
    int               last_valid_cyc = -1;
    int               done_cyc = -1;
    logic [BANK*OW-1:0] last_data = '0;
    logic [DW-1:0]    model_cent = '0;
    beat_t            sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every out_valid beat must match the head of the queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                n_out++;
                last_valid_cyc = cyc;
                last_data = out_data;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_beat: got out_valid=1 at cycle %0d, required no beat", cyc);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    if (out_mask !== e.mask || out_rep !== e.rep || out_data !== e.data)
                        $display("FAIL sb_beat: got mask=%h rep=%0d data=%h, required mask=%h rep=%0d data=%h",
                                 out_mask, out_rep, out_data, e.mask, e.rep, e.data);
                    else
                        n_pass++;
                end
            end
        end
    end

    function automatic logic [OW-1:0] rel(input logic [DW-1:0] n, input logic [DW-1:0] c);
        int d;
        d = $signed(n) - $signed(c);
        return d[OW-1:0];
    endfunction

    function automatic logic [BANK*AW-1:0] uaddr(input logic [AW-1:0] a);
        return {BANK{a}};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request cycle; the model is updated at the moment of driving.
    task automatic issue(input logic c, input logic n, input logic [BANK-1:0] v,
                         input logic [BANK*AW-1:0] a, input logic [1:0] rep, input logic done);
        is_centroid = c;
        is_neighbor = n;
        valid       = v;
        PFT_addr    = a;
        repetition  = rep;
        NIT_done    = done;
        if (c) begin
            for (int i = 0; i < BANK; i++) begin
                if (v[i]) begin
                    model_cent = mem[i][a[i*AW +: AW]];
                    break;
                end
            end
        end else if (n) begin
            beat_t e;
            e.mask = v;
            e.rep  = rep;
            e.data = '0;
            for (int i = 0; i < BANK; i++) begin
                if (v[i]) e.data[i*OW +: OW] = rel(mem[i][a[i*AW +: AW]], model_cent);
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        is_centroid = 1'b0;
        is_neighbor = 1'b0;
        valid       = '0;
        PFT_addr    = '0;
        repetition  = '0;
        NIT_done    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        sb.delete();
        model_cent = '0;
        idle(2);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ((|{bank_en, bank_addr, out_valid, out_mask, out_data, out_rep,
                   out_done, group_count, err}) !== 1'b0)
                $display("FAIL reset_idle: cycle %0d got bank_en=%h out_valid=%b gc=%0d err=%b, required all 0",
                         k, bank_en, out_valid, group_count, err);
            else
                n_pass++;
            idle(1);
        end
    endtask

    task automatic test_centroid();
        mem[5][7] = 16'd100;
        for (int i = 0; i < BANK; i++) mem[i][3] = DW'(i * 10);
        pulse_start();
        issue(1'b1, 1'b0, 32'h1 << 5, uaddr(5'd7), 2'd0, 1'b0);
        issue(1'b0, 1'b1, '1, uaddr(5'd3), 2'd2, 1'b0);
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL cent_latency_early: got out_valid=%b at T+2, required 0", out_valid);
        else n_pass++;
        idle(1);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL cent_latency: got out_valid=%b at T+3, required 1", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data[9*OW +: OW] !== 17'h1FFF6 || out_data[0 +: OW] !== 17'h1FF9C)
            $display("FAIL cent_lane_values: got lane9=%h lane0=%h, required 1fff6 1ff9c",
                     out_data[9*OW +: OW], out_data[0 +: OW]);
        else n_pass++;
        n_checks++;
        if (out_rep !== 2'd2) $display("FAIL cent_rep: got %0d, required 2", out_rep);
        else n_pass++;
        n_checks++;
        if (group_count !== 13'd1 || err !== 1'b0)
            $display("FAIL cent_count: got gc=%0d err=%b, required gc=1 err=0", group_count, err);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_signed();
        mem[0][1] = 16'h8000;
        mem[0][2] = 16'h7FFF;
        mem[1][2] = 16'h8000;
        mem[0][4] = 16'h7FFF;
        mem[0][5] = 16'h8000;
        pulse_start();
        issue(1'b1, 1'b0, 32'h1, uaddr(5'd1), 2'd0, 1'b0);
        issue(1'b0, 1'b1, 32'h3, uaddr(5'd2), 2'd1, 1'b0);
        idle(4);
        n_checks++;
        if (last_data[0 +: OW] !== 17'h0FFFF || last_data[OW +: OW] !== 17'h0 || last_data[2*OW +: OW] !== 17'h0)
            $display("FAIL signed_max: got lane0=%h lane1=%h lane2=%h, required 0ffff 0 0",
                     last_data[0 +: OW], last_data[OW +: OW], last_data[2*OW +: OW]);
        else n_pass++;
        issue(1'b1, 1'b0, 32'h1, uaddr(5'd4), 2'd0, 1'b0);
        issue(1'b0, 1'b1, 32'h1, uaddr(5'd5), 2'd3, 1'b0);
        idle(4);
        n_checks++;
        if (last_data[0 +: OW] !== 17'h10001)
            $display("FAIL signed_min: got lane0=%h, required 10001", last_data[0 +: OW]);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0 || group_count !== 13'd2)
            $display("FAIL signed_state: got err=%b gc=%0d, required err=0 gc=2", err, group_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int out0, done0;
        logic [BANK*AW-1:0] a;
        for (int i = 0; i < BANK; i++)
            for (int j = 8; j < 32; j++) mem[i][j] = DW'($urandom);
        pulse_start();
        out0  = n_out;
        done0 = n_done;
        for (int g = 0; g < 3; g++) begin
            issue(1'b1, 1'b0, 32'h1 << (g * 7 + 3), uaddr(AW'(8 + g)), 2'd0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < BANK; i++) a[i*AW +: AW] = AW'($urandom_range(8, 31));
                issue(1'b0, 1'b1, $urandom | 32'h1, a, 2'(k), 1'b0);
            end
        end
        issue(1'b0, 1'b0, '0, '0, 2'd0, 1'b1);
        idle(6);
        n_checks++;
        if (n_out - out0 !== 12) $display("FAIL b2b_beats: got %0d out_valid, required 12", n_out - out0);
        else n_pass++;
        n_checks++;
        if (group_count !== 13'd3) $display("FAIL b2b_groups: got gc=%0d, required 3", group_count);
        else n_pass++;
        n_checks++;
        if (n_done - done0 !== 1 || done_cyc !== last_valid_cyc + 1)
            $display("FAIL b2b_done: got %0d pulses at cycle %0d (last valid %0d), required 1 pulse one cycle after",
                     n_done - done0, done_cyc, last_valid_cyc);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL b2b_err: got err=%b, required 0", err);
        else n_pass++;
        // cent_ok has dropped with out_done: a neighbour now is a protocol error.
        issue(1'b0, 1'b1, 32'h1, uaddr(5'd9), 2'd0, 1'b0);
        idle(3);
        n_checks++;
        if (err !== 1'b1) $display("FAIL b2b_centok_clear: got err=%b, required 1", err);
        else n_pass++;
    endtask

    task automatic test_errors();
        for (int i = 0; i < BANK; i++) mem[i][6] = DW'($urandom);
        mem[4][6] = 16'd1234;
        pulse_start();
        n_checks++;
        if (err !== 1'b0 || group_count !== 13'd0)
            $display("FAIL err_start_clear: got err=%b gc=%0d, required 0 0", err, group_count);
        else n_pass++;
        issue(1'b1, 1'b1, 32'h1 << 4, uaddr(5'd6), 2'd0, 1'b0);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_both_kinds: got err=%b, required 1", err);
        else n_pass++;
        issue(1'b0, 1'b1, 32'hF0, uaddr(5'd6), 2'd1, 1'b0);
        idle(5);
        n_checks++;
        if (err !== 1'b1 || group_count !== 13'd1)
            $display("FAIL err_both_hold: got err=%b gc=%0d, required err=1 gc=1", err, group_count);
        else n_pass++;

        pulse_start();
        for (int i = 0; i < BANK; i++) mem[i][9] = DW'($urandom);
        mem[0][9] = 16'hFFFB;
        mem[1][9] = 16'd77;
        issue(1'b1, 1'b0, 32'h3, uaddr(5'd9), 2'd0, 1'b0);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_multihot: got err=%b, required 1", err);
        else n_pass++;
        issue(1'b0, 1'b1, '1, uaddr(5'd9), 2'd2, 1'b0);
        idle(5);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_multihot_hold: got err=%b, required 1", err);
        else n_pass++;

        do_reset();
        issue(1'b0, 1'b1, '1, uaddr(5'd9), 2'd3, 1'b0);
        idle(1);
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_nocent_early: got err=%b at T+2, required 0", err);
        else n_pass++;
        idle(1);
        n_checks++;
        if (err !== 1'b1) $display("FAIL err_nocent: got err=%b, required 1", err);
        else n_pass++;
        idle(5);
        pulse_start();
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_cleared: got err=%b, required 0", err);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        mem[0][1] = 16'd50;
        pulse_start();
        issue(1'b1, 1'b0, 32'h1, uaddr(5'd1), 2'd0, 1'b0);
        idle(3);
        issue(1'b0, 1'b1, '1, uaddr(5'd2), 2'd1, 1'b0);
        idle(1);
        rstn = 1'b0;
        sb.delete();
        model_cent = '0;
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midrun_flush: got out_valid=%b, required 0", out_valid);
        else n_pass++;
        rstn = 1'b1;
        idle(1);
        n_checks++;
        if (bank_en !== '0 || out_valid !== 1'b0)
            $display("FAIL midrun_release: got bank_en=%h out_valid=%b, required 0 0", bank_en, out_valid);
        else n_pass++;
        idle(3);
        n_checks++;
        if (out_valid !== 1'b0 || group_count !== 13'd0)
            $display("FAIL midrun_quiet: got out_valid=%b gc=%0d, required 0 0", out_valid, group_count);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < BANK; i++)
            for (int j = 0; j < 32; j++) mem[i][j] = '0;
        test_reset();
        test_centroid();
        test_signed();
        test_back_to_back();
        test_errors();
        test_reset_midrun();
        idle(4);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL sb_drain: got %0d beats outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
